rstval_sequencer: RTL

Controller for a bank of registers that use a non-constant asynchronous reset value. It holds the programmable reset value for each channel and drives it onto that channel's reset-value input. It also sequences each channel's active-low reset: asynchronous assertion, synchronized and staggered release. A soft-reset request re-runs the sequence without a global reset.

---
 rtl/rstval_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/rstval_sequencer.sv
// -----------------------------------------------------------------------------
// rstval_sequencer
//
// Reset controller for a bank of datapath registers whose asynchronous reset
// value is not a constant. For each channel it holds a programmable reset
// value and drives it on ch_reset_value. It also sequences that channel's
// active-low reset. Assertion is asynchronous. Release is synchronized, then
// staggered one channel at a time. A soft-reset request re-runs the whole
// sequence without a global reset.
//
// Ports:
//   clk            clock
//   rstn           asynchronous active-low reset
//   soft_rst_req   level-sampled request to re-run the reset sequence
//   cfg_valid      config write valid
//   cfg_ready      config write ready (high only in RUN, and only while unlocked)
//   cfg_ch         target channel of a config write
//   cfg_val        reset value written to the target channel
//   cfg_lock       (only with RSTVAL_SEQ_LOCK_EN) sticky lock of config writes
//   ch_rstn        per-channel active-low reset to the datapath registers
//   ch_reset_value per-channel reset value to the datapath registers
//   busy           sequence in progress
//   done           one-cycle pulse when the last channel is released
//
// Build option: define RSTVAL_SEQ_LOCK_EN to add the cfg_lock input.
// -----------------------------------------------------------------------------
module rstval_sequencer #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD        = 8,
    parameter int REL_GAP     = 4,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            soft_rst_req,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [CH_W-1:0] cfg_ch,
    input  logic            cfg_val,
`ifdef RSTVAL_SEQ_LOCK_EN
    input  logic            cfg_lock,
`endif
    output logic [N_CH-1:0] ch_rstn,
    output logic [N_CH-1:0] ch_reset_value,
    output logic            busy,
    output logic            done
);

    localparam int CNT_MAX = (HOLD > REL_GAP) ? HOLD : REL_GAP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   idx_q, idx_d;      // next channel to release
    logic              rel_now;           // a channel is released on this edge
    logic              locked_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic              sync_ok;
    logic [N_CH-1:0]   ch_rstn_d;
    logic              busy_d, done_d, cfg_ready_d;
    logic              wr_en;

    // Release synchronizer: cleared asynchronously, shifts in ones, so the
    // FSM only leaves reset a fixed number of clean edges after rstn rises.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            // NOTE: sequential state always uses <=, so every flop samples
            // the pre-edge values and the order of statements is irrelevant.
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_ok = sync_q[SYNC_STAGES-1];

    // State register plus all registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_ASSERT;
            cnt_q     <= '0;
            idx_q     <= '0;
            ch_rstn   <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            cfg_ready <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            ch_rstn   <= ch_rstn_d;
            busy      <= busy_d;
            done      <= done_d;
            cfg_ready <= cfg_ready_d;
        end
    end

    // Next-state logic. A soft reset outranks everything once the
    // synchronizer is high. A cfg write in the same cycle is handled
    // independently below, so it is still taken.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; that is what keeps this block free of latches.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rel_now = 1'b0;
        if (sync_ok) begin
            if (soft_rst_req) begin
                state_d = ST_ASSERT;
                cnt_d   = '0;
                idx_d   = '0;
            end else begin
                case (state_q)
                    ST_ASSERT, ST_RELEASE: begin
                        if (cnt_q == CNT_W'((state_q == ST_ASSERT) ? HOLD - 1 : REL_GAP - 1)) begin
                            rel_now = 1'b1;
                            cnt_d   = '0;
                            if (idx_q == CH_W'(N_CH - 1)) begin
                                state_d = ST_RUN;
                            end else begin
                                state_d = ST_RELEASE;
                                idx_d   = idx_q + 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef RSTVAL_SEQ_LOCK_EN
    // Sticky lock: survives soft reset, cleared only by rstn.
    logic lock_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= locked_d;
        end
    end

    assign locked_d = lock_q | ((state_q == ST_RUN) & cfg_lock);
`else
    assign locked_d = 1'b0;
`endif

    // Output logic: next values of the registered outputs.
    always_comb begin
        ch_rstn_d   = ch_rstn;
        busy_d      = (state_d != ST_RUN);
        done_d      = rel_now & (state_d == ST_RUN);
        cfg_ready_d = (state_d == ST_RUN) & ~locked_d;
        if (sync_ok && soft_rst_req) begin
            ch_rstn_d = '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (rel_now && idx_q == CH_W'(i)) begin
                    ch_rstn_d[i] = 1'b1;
                end
            end
        end
    end

    // Config writes only happen while cfg_ready is high, which means in RUN.
    // So ch_reset_value never moves while any channel is being released.
    // A write to a channel number that does not exist completes without
    // any effect.
    assign wr_en = cfg_valid & cfg_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: this value bank is reset on purpose. The datapath uses
            // ch_reset_value while its own reset is asserted, so it must
            // be defined from the very first cycle. Programmed values are
            // therefore lost on rstn.
            ch_reset_value <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (wr_en && cfg_ch == CH_W'(i)) begin
                    ch_reset_value[i] <= cfg_val;
                end
            end
        end
    end

endmodule
